ball_controller: RTL and testbench
==================================

# ball_controller

Per-frame game sequencer that owns the ball position fed to the pixel renderer (`i_screen_ball_x/y`). It integrates button-driven velocity once per frame and bounces the ball off the screen edges. It samples the renderer's safe-zone flag under the ball centre and runs the IDLE/RUN/DEAD game state machine. It sits between the VGA timing generator, the debounced button inputs and the renderer.

## Interface
- `SCREEN_WIDTH`, 800, visible width in pixels
- `SCREEN_HEIGHT`, 600, visible height in pixels
- `BALL_RADIUS`, 20, ball radius in pixels; same value the renderer uses
- `MAX_SPEED`, 8, velocity saturation magnitude, pixels/frame per axis
- `START_X`, 400, ball x in IDLE and after reset
- `START_Y`, 300, ball y in IDLE and after reset

Ports:
- `i_clk`  in  1  pixel clock; the only clock
- `i_rst_n`  in  1  reset, synchronous, active-low
- `i_frame_end`  in  1  one-cycle pulse after the last visible pixel of a frame
- `i_start`  in  1  one-cycle pulse; start game or restart after death
- `i_btn_up`, `i_btn_down`, `i_btn_left`, `i_btn_right`  in  1 each  debounced level inputs
- `i_pixel_x`  in  $clog2(SCREEN_WIDTH)  current renderer pixel x
- `i_pixel_y`  in  $clog2(SCREEN_HEIGHT)  current renderer pixel y
- `i_pixel_valid`  in  1  pixel is inside the visible area
- `i_is_safe`  in  1  safe-zone flag for the current pixel
- `o_ball_x`  out  $clog2(SCREEN_WIDTH)  ball centre x
- `o_ball_y`  out  $clog2(SCREEN_HEIGHT)  ball centre y
- `o_state`  out  2  0=IDLE, 1=RUN, 2=DEAD
- `o_game_over`  out  1  high while in DEAD

## Operation
- Reset state:
  - IDLE, ball at (START_X, START_Y), vx=vy=0, o_game_over=0.
  - Safety flag cleared; capture flag cleared.
- IDLE:
  - Ball is held at start position; velocity is 0.
  - `i_start` → RUN.
- RUN, during a frame:
  - When `i_pixel_valid` and (`i_pixel_x`,`i_pixel_y`) equals (`o_ball_x`,`o_ball_y`), register `center_safe`=`i_is_safe` and set `captured`=1.
- RUN, on `i_frame_end`, steps in this order:
  1. Death check: if `captured` && !`center_safe` → DEAD. Position and velocity are frozen this frame.
  2. Velocity: right/left add +1/−1 to vx; down/up add +1/−1 to vy. Opposing buttons both pressed give no change. Saturate at ±MAX_SPEED.
  3. Position per axis: p' = p + v', computed in signed 12-bit.
     - If p' < R: p = R, v = −v'.
     - If p' > W−1−R (H−1−R for y): p = W−1−R, v = −v'.
     - Otherwise p = p'.
  4. Clear `captured` and `center_safe`.
- No capture during a frame counts as safe.
- DEAD:
  - Position held; o_game_over=1.
  - `i_start` → IDLE, which reloads the start position and zeroes velocity.
- Simultaneous events:
  - `i_start` and `i_frame_end` in IDLE: start wins; no physics on that frame end.
  - `i_start` in RUN is ignored.
- Width rules:
  - Velocity is signed, $clog2(MAX_SPEED)+2 bits.
  - Clamped outputs are always within [R, W−1−R] and [R, H−1−R].

## Timing
- `o_ball_x/y` and `o_state` update on the clock edge that samples `i_frame_end`; new values are visible the next cycle, during blanking.
- Capture has one cycle of latency: it compares against registered `o_ball_x/y`, which are stable for the whole visible frame.
- `i_start` is acted on at the sampling edge; `o_state` changes the next cycle.
- Reset mid-frame: the next edge with `i_rst_n`=0 forces full reset values regardless of state.

## Structure
- Package `ball_pkg`:
  - `game_state_t` enum (IDLE/RUN/DEAD, 2-bit).
  - Default constants START_X/START_Y/MAX_SPEED.
- Sub-module `axis_bounce`, instantiated twice (x with W, y with H):
  - Combinational velocity saturate, position add, and clamp/reflect.
  - Parameters: axis size, radius, MAX_SPEED.
- Top level holds the FSM, the capture logic and the registers.

## Test plan
- Reset, then `i_start`, then 3 frames holding `i_btn_right` with `i_is_safe`=1 → vx=1,2,3; x=401,403,406; y=300; o_state=1.
- x=775, vx=+8, frame end → x=779 (W−1−R), vx=−8; next frame x=771.
- Hold right 20 frames from standstill → vx saturates at +8, never 9.
- `i_is_safe`=0 at the ball-centre pixel in RUN, then `i_frame_end` → o_state=2, o_game_over=1, position unchanged; further frame ends do not move the ball.
- In DEAD, `i_start` → IDLE, ball at (400,300), vx=vy=0; `i_start` and `i_frame_end` in the same cycle in IDLE → RUN with no movement.
- Assert `i_rst_n`=0 mid-frame in RUN → next cycle IDLE, (400,300), o_game_over=0; a safe flag captured before the reset does not affect the following frame.

Source files
------------

// File: rtl/ball_pkg.sv
// ball_pkg: shared game-state encoding and default ball constants.
package ball_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} game_state_t;
    localparam int DEFAULT_START_X   = 400;
    localparam int DEFAULT_START_Y   = 300;
    localparam int DEFAULT_MAX_SPEED = 8;
endpackage

// File: rtl/axis_bounce.sv
// axis_bounce: one-axis velocity saturate, position integrate and edge clamp/reflect.
module axis_bounce
    import ball_pkg::*;
#(
    parameter int SIZE      = 800,
    parameter int RADIUS    = 20,
    parameter int MAX_SPEED = DEFAULT_MAX_SPEED,
    localparam int PW = $clog2(SIZE),
    localparam int VW = $clog2(MAX_SPEED) + 2
) (
    input  logic [PW-1:0]        pos,
    input  logic signed [VW-1:0] vel,
    input  logic                 inc,
    input  logic                 dec,
    output logic [PW-1:0]        pos_next,
    output logic signed [VW-1:0] vel_next
);
    localparam logic signed [VW:0] ONE  = 1;
    localparam logic signed [VW:0] ZERO = 0;
    localparam logic signed [VW:0] VMAX = MAX_SPEED;
    localparam logic signed [VW:0] VMIN = -MAX_SPEED;
    localparam logic signed [11:0] LO   = RADIUS;
    localparam logic signed [11:0] HI   = SIZE - 1 - RADIUS;
    logic signed [VW:0]   v_sum;
    logic signed [VW-1:0] v_sat;
    logic signed [11:0]   p_sum;
    always_comb begin
        v_sum    = {vel[VW-1], vel} + ((inc && !dec) ? ONE : (dec && !inc) ? -ONE : ZERO);
        v_sat    = v_sum > VMAX ? VW'(VMAX) : v_sum < VMIN ? VW'(VMIN) : v_sum[VW-1:0];
        // position math is done wide and signed so underflow past 0 is visible
        p_sum    = $signed({{(12-PW){1'b0}}, pos}) + $signed({{(12-VW){v_sat[VW-1]}}, v_sat});
        pos_next = p_sum < LO ? PW'(RADIUS) : p_sum > HI ? PW'(SIZE - 1 - RADIUS) : p_sum[PW-1:0];
        vel_next = (p_sum < LO || p_sum > HI) ? -v_sat : v_sat;
    end
endmodule

// File: rtl/ball_controller.sv
// ball_controller: per-frame ball physics, centre safe-zone capture and IDLE/RUN/DEAD sequencing.
module ball_controller
    import ball_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_RADIUS   = 20,
    parameter int MAX_SPEED     = DEFAULT_MAX_SPEED,
    parameter int START_X       = DEFAULT_START_X,
    parameter int START_Y       = DEFAULT_START_Y,
    localparam int XW = $clog2(SCREEN_WIDTH),
    localparam int YW = $clog2(SCREEN_HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_frame_end,
    input  logic          i_start,
    input  logic          i_btn_up,
    input  logic          i_btn_down,
    input  logic          i_btn_left,
    input  logic          i_btn_right,
    input  logic [XW-1:0] i_pixel_x,
    input  logic [YW-1:0] i_pixel_y,
    input  logic          i_pixel_valid,
    input  logic          i_is_safe,
    output logic [XW-1:0] o_ball_x,
    output logic [YW-1:0] o_ball_y,
    output logic [1:0]    o_state,
    output logic          o_game_over
);
    localparam int VW = $clog2(MAX_SPEED) + 2;
    game_state_t          state, state_next;
    logic [XW-1:0]        ball_x, x_next;
    logic [YW-1:0]        ball_y, y_next;
    logic signed [VW-1:0] vx, vy, vx_next, vy_next;
    logic                 captured, center_safe, die, step;

    axis_bounce #(.SIZE(SCREEN_WIDTH), .RADIUS(BALL_RADIUS), .MAX_SPEED(MAX_SPEED)) u_x (
        .pos(ball_x), .vel(vx), .inc(i_btn_right), .dec(i_btn_left),
        .pos_next(x_next), .vel_next(vx_next)
    );

    axis_bounce #(.SIZE(SCREEN_HEIGHT), .RADIUS(BALL_RADIUS), .MAX_SPEED(MAX_SPEED)) u_y (
        .pos(ball_y), .vel(vy), .inc(i_btn_down), .dec(i_btn_up),
        .pos_next(y_next), .vel_next(vy_next)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        // a frame with no capture counts as safe
        die        = state == RUN && i_frame_end && captured && !center_safe;
        step       = state == RUN && i_frame_end && !die;
        case (state)
            IDLE:    state_next = i_start ? RUN : IDLE;
            RUN:     state_next = die ? DEAD : RUN;
            DEAD:    state_next = i_start ? IDLE : DEAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || (state == DEAD && i_start)) begin
            ball_x <= XW'(START_X);
            ball_y <= YW'(START_Y);
            vx     <= '0;
            vy     <= '0;
        end else if (step) begin
            ball_x <= x_next;
            ball_y <= y_next;
            vx     <= vx_next;
            vy     <= vy_next;
        end
    end

    // compares against the registered ball position, stable across the visible frame
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || state != RUN || i_frame_end) begin
            captured    <= 1'b0;
            center_safe <= 1'b0;
        end else if (i_pixel_valid && i_pixel_x == ball_x && i_pixel_y == ball_y) begin
            captured    <= 1'b1;
            center_safe <= i_is_safe;
        end
    end

    assign o_ball_x    = ball_x;
    assign o_ball_y    = ball_y;
    assign o_state     = state;
    assign o_game_over = state == DEAD;
endmodule

// File: tb/tb_ball_controller.sv
// tb_ball_controller: randomized scoreboard bench against a frame-level game model.
module tb_ball_controller;
    logic       clk = 0, rst_n = 0, frame_end = 0, start = 0;
    logic       up = 0, down = 0, left = 0, right = 0, pv = 0, safe = 0;
    logic [9:0] px = 0, py = 0;
    logic [9:0] o_ball_x, o_ball_y;
    logic [1:0] o_state;
    logic       o_game_over;

    typedef struct {int st; int x; int y;} exp_t;
    exp_t q[$];
    int   m_st, m_x, m_y, m_vx, m_vy;
    bit   m_cap, m_safe;
    int   n_vec = 0, n_fail = 0;

    always #5 clk = ~clk;

    ball_controller dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_end(frame_end), .i_start(start),
        .i_btn_up(up), .i_btn_down(down), .i_btn_left(left), .i_btn_right(right),
        .i_pixel_x(px), .i_pixel_y(py), .i_pixel_valid(pv), .i_is_safe(safe),
        .o_ball_x(o_ball_x), .o_ball_y(o_ball_y), .o_state(o_state), .o_game_over(o_game_over)
    );

    task automatic axis(inout int p, inout int v, input bit inc, input bit dec, input int size);
        if (inc && !dec) v = v + 1;
        if (dec && !inc) v = v - 1;
        if (v > 8) v = 8;
        if (v < -8) v = -8;
        p = p + v;
        if (p < 20) begin
            p = 20;
            v = -v;
        end else if (p > size - 21) begin
            p = size - 21;
            v = -v;
        end
    endtask

    task automatic home();
        m_x = 400; m_y = 300; m_vx = 0; m_vy = 0;
    endtask

    // b = {up, down, left, right}
    task automatic tick(input bit s, input bit fe, input bit r, input bit [3:0] b,
                        input bit v, input int x, input int y, input bit sf);
        @(negedge clk);
        start = s; frame_end = fe; rst_n = !r; {up, down, left, right} = b;
        pv = v; px = 10'(x); py = 10'(y); safe = sf;
        if (r) begin
            m_st = 0; home(); m_cap = 0; m_safe = 0;
        end else if (m_st == 0) begin
            if (s) m_st = 1;
        end else if (m_st == 1) begin
            if (fe) begin
                if (m_cap && !m_safe) m_st = 2;
                else begin
                    axis(m_x, m_vx, b[0], b[1], 800);
                    axis(m_y, m_vy, b[2], b[3], 600);
                end
                m_cap = 0; m_safe = 0;
            end else if (v && x == m_x && y == m_y) begin
                m_cap = 1; m_safe = sf;
            end
        end else if (s) begin
            m_st = 0; home();
        end
        if (s || fe || r) q.push_back('{m_st, m_x, m_y});
    endtask

    task automatic idle();
        tick(0, 0, 0, 4'b0, 0, 0, 0, 0);
    endtask

    task automatic pix(input bit v, input int x, input int y, input bit sf);
        tick(0, 0, 0, 4'b0, v, x, y, sf);
    endtask

    task automatic fend(input bit [3:0] b);
        tick(0, 1, 0, b, 0, 0, 0, 0);
    endtask

    task automatic safe_frame(input bit [3:0] b);
        pix(1, m_x, m_y, 1);
        fend(b);
        idle();
    endtask

    initial begin : monitor
        bit   ev;
        exp_t e;
        @(negedge clk);
        forever begin
            @(posedge clk);
            ev = start || frame_end || !rst_n;
            @(negedge clk);
            if (ev) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL vec%0d: DUT event with no queued expectation", n_vec);
                end else begin
                    e = q.pop_front();
                    if (o_state !== 2'(e.st) || o_ball_x !== 10'(e.x) || o_ball_y !== 10'(e.y)
                        || o_game_over !== (e.st == 2)) begin
                        n_fail++;
                        $display("FAIL vec%0d: got state=%0d x=%0d y=%0d over=%0b, want state=%0d x=%0d y=%0d over=%0b",
                                 n_vec, o_state, o_ball_x, o_ball_y, o_game_over, e.st, e.x, e.y, e.st == 2);
                    end
                end
            end
        end
    end

    initial begin
        m_st = 0; home(); m_cap = 0; m_safe = 0;
        tick(0, 0, 1, 4'b0, 0, 0, 0, 0);
        tick(0, 0, 1, 4'b0, 0, 0, 0, 0);
        idle();
        tick(1, 0, 0, 4'b0, 0, 0, 0, 0);
        idle();
        for (int i = 0; i < 20; i++) safe_frame(4'b0001);
        for (int i = 0; i < 60 && m_x < 775; i++) safe_frame(4'b0001);
        for (int i = 0; i < 4; i++) safe_frame(4'b0000);
        for (int i = 0; i < 6; i++) safe_frame(4'b1000);
        pix(0, m_x, m_y, 0);
        fend(4'b0010);
        idle();
        pix(1, m_x, m_y, 0);
        pix(1, m_x + 1, m_y, 1);
        fend(4'b0001);
        for (int i = 0; i < 3; i++) begin
            pix(1, m_x, m_y, 1);
            fend(4'b0101);
        end
        tick(1, 0, 0, 4'b0, 0, 0, 0, 0);
        idle();
        tick(1, 1, 0, 4'b0001, 0, 0, 0, 0);
        idle();
        safe_frame(4'b0001);
        pix(1, m_x, m_y, 0);
        tick(0, 0, 1, 4'b0, 0, 0, 0, 0);
        idle();
        tick(1, 0, 0, 4'b0, 0, 0, 0, 0);
        fend(4'b0100);
        idle();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                tick(0, 0, 1, 4'b0, 0, 0, 0, 0);
            end else if (r < 10 || (m_st != 1 && $urandom_range(0, 2) == 0)) begin
                tick(1, 0, 0, 4'(($urandom)), 0, 0, 0, 0);
            end else if (r < 13) begin
                tick(1, 1, 0, 4'(($urandom)), 0, 0, 0, 0);
            end else begin
                int n;
                n = int'($urandom_range(1, 4));
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 2) == 0)
                        pix($urandom_range(0, 3) != 0, m_x, m_y, $urandom_range(0, 9) != 0);
                    else
                        pix($urandom_range(0, 1) == 1, int'($urandom_range(0, 799)),
                            int'($urandom_range(0, 599)), $urandom_range(0, 1) == 1);
                end
                fend(4'(($urandom)));
            end
        end
        idle();
        idle();
        idle();
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never matched by a DUT event, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
